// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : MIPS IF stage - PC, instruction SRAM port, decode-stall hold
//             buffer (built only when IF_HOLD_BUF_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic [31:0]        inst_sram_rdata,
    output logic [31:0]        id_inst
);

    typedef enum logic [1:0] {
        S_BUBBLE = 2'd0,
        S_PASS   = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ce;
    logic [31:0] w_next_pc;
    logic        w_id_stall;
    logic        w_id_bub;
    logic        w_id_go;
    logic        w_unused_stall;

    assign w_next_pc  = br_bus[32] ? br_bus[31:0] : r_pc + 32'd4;
    assign w_id_stall = stall[1] & stall[2];
    assign w_id_bub   = stall[1] & ~stall[2];
    assign w_id_go    = ~stall[1];

    // Stages beyond EX do not affect fetch.
    assign w_unused_stall = ^stall[STALL_W-1:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC - 32'd4;
            r_ce <= 1'b0;
        end else if (!stall[0]) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

`ifdef IF_HOLD_BUF_EN
    logic [31:0] r_hold_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BUBBLE;
            r_hold_inst <= 32'h0;
        end else begin
            case (r_state)
                S_BUBBLE: if (w_id_go && r_ce) r_state <= S_PASS;
                S_PASS: begin
                    if (w_id_stall) begin
                        r_state     <= S_HOLD;
                        r_hold_inst <= inst_sram_rdata;
                    end else if (w_id_bub || (w_id_go && !r_ce)) begin
                        r_state <= S_BUBBLE;
                    end
                end
                S_HOLD: begin
                    if (w_id_go)       r_state <= r_ce ? S_PASS : S_BUBBLE;
                    else if (w_id_bub) r_state <= S_BUBBLE;
                end
                default: r_state <= S_BUBBLE;
            endcase
        end
    end

    always_comb begin
        id_inst = 32'h0;
        case (r_state)
            S_PASS:  id_inst = inst_sram_rdata;
            S_HOLD:  id_inst = r_hold_inst;
            default: id_inst = 32'h0;
        endcase
    end
`else
    // Without the hold buffer a decode stall leaves PASS streaming raw SRAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BUBBLE;
        end else begin
            case (r_state)
                S_BUBBLE: if (w_id_go && r_ce) r_state <= S_PASS;
                S_PASS:   if (w_id_bub || (w_id_go && !r_ce)) r_state <= S_BUBBLE;
                default:  r_state <= S_BUBBLE;
            endcase
        end
    end

    always_comb begin
        id_inst = 32'h0;
        if (r_state == S_PASS) id_inst = inst_sram_rdata;
    end
`endif

    assign if_to_id_bus    = {r_ce, r_pc};
    assign inst_sram_en    = r_ce;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire
